// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one I2C write master between NUM_REQ requesters.
// Tracks the PCA9548 mux channel and inserts a channel-select write when the granted requester needs one.
module i2c_bus_arbiter #(
    parameter int         NUM_REQ        = 3,
    parameter logic [6:0] MUX_ADDR       = 7'h74,
    parameter int         TIMEOUT_CYCLES = 1048576
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ*7-1:0] req_slave_addr,
    input  logic [NUM_REQ*8-1:0] req_reg_addr,
    input  logic [NUM_REQ*8-1:0] req_write_data,
    input  logic [NUM_REQ-1:0]   req_single_byte,
    input  logic [NUM_REQ*8-1:0] req_channel,
    input  logic [NUM_REQ-1:0]   req_write_req,
    output logic [NUM_REQ-1:0]   req_busy,
    output logic [NUM_REQ-1:0]   req_done,
    output logic [NUM_REQ-1:0]   req_ack_error,
    output logic [6:0]           i2c_slave_addr,
    output logic [7:0]           i2c_reg_addr,
    output logic [7:0]           i2c_write_data,
    output logic                 i2c_single_byte,
    output logic                 i2c_write_req,
    input  logic                 i2c_busy,
    input  logic                 i2c_done,
    input  logic                 i2c_ack_error
);

    localparam int GW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ARB,
        ST_MUX_SEND,
        ST_MUX_WAIT_BUSY,
        ST_MUX_WAIT_DONE,
        ST_XFER_SEND,
        ST_XFER_WAIT_BUSY,
        ST_XFER_WAIT_DONE,
        ST_COMPLETE
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_REQ-1:0]  pending_q, pending_d;
    logic [GW-1:0]       grant_q, grant_d;
    logic [GW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]       rr_pick;
    logic                rr_found;
    logic [7:0]          cur_chan_q, cur_chan_d;
    logic                chan_valid_q, chan_valid_d;
    logic [WD_W-1:0]     watchdog_q, watchdog_d;
    logic                error_q, error_d;

    logic [6:0]          out_slave_q, out_slave_d;
    logic [7:0]          out_reg_q, out_reg_d;
    logic [7:0]          out_data_q, out_data_d;
    logic                out_single_q, out_single_d;
    logic                out_wreq_q, out_wreq_d;

    logic [6:0]          lat_slave_q  [NUM_REQ];
    logic [6:0]          lat_slave_d  [NUM_REQ];
    logic [7:0]          lat_reg_q    [NUM_REQ];
    logic [7:0]          lat_reg_d    [NUM_REQ];
    logic [7:0]          lat_data_q   [NUM_REQ];
    logic [7:0]          lat_data_d   [NUM_REQ];
    logic [7:0]          lat_chan_q   [NUM_REQ];
    logic [7:0]          lat_chan_d   [NUM_REQ];
    logic [NUM_REQ-1:0]  lat_single_q, lat_single_d;

    logic [6:0]          sel_slave;
    logic [7:0]          sel_reg;
    logic [7:0]          sel_data;
    logic [7:0]          sel_chan;
    logic                sel_single;
    logic                mux_needed;
    logic                wd_expired;
    logic [NUM_REQ-1:0]  grant_onehot;
    logic [GW:0]         cand;

    assign grant_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q;

    // Completion status is decoded straight from the state so busy drops in the done cycle.
    assign req_done      = (state_q == ST_COMPLETE) ? grant_onehot : '0;
    assign req_ack_error = (state_q == ST_COMPLETE && error_q) ? grant_onehot : '0;
    assign req_busy      = pending_q & ~req_done;

    assign i2c_slave_addr  = out_slave_q;
    assign i2c_reg_addr    = out_reg_q;
    assign i2c_write_data  = out_data_q;
    assign i2c_single_byte = out_single_q;
    assign i2c_write_req   = out_wreq_q;

    assign sel_slave  = lat_slave_q[grant_q];
    assign sel_reg    = lat_reg_q[grant_q];
    assign sel_data   = lat_data_q[grant_q];
    assign sel_chan   = lat_chan_q[grant_q];
    assign sel_single = lat_single_q[grant_q];

    assign mux_needed = (sel_slave != MUX_ADDR) && (!chan_valid_q || cur_chan_q != sel_chan);
    assign wd_expired = (watchdog_q == WD_LIMIT);

    always_comb begin
        rr_pick  = '0;
        rr_found = 1'b0;
        cand     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (GW+1)'(k);
            if (cand >= (GW+1)'(NUM_REQ)) begin
                cand = cand - (GW+1)'(NUM_REQ);
            end
            if (!rr_found && pending_q[cand[GW-1:0]]) begin
                rr_found = 1'b1;
                rr_pick  = cand[GW-1:0];
            end
        end
    end

    // Capture is evaluated after the completion clear so a same-cycle re-request survives.
    always_comb begin
        pending_d    = pending_q;
        lat_slave_d  = lat_slave_q;
        lat_reg_d    = lat_reg_q;
        lat_data_d   = lat_data_q;
        lat_chan_d   = lat_chan_q;
        lat_single_d = lat_single_q;
        if (state_q == ST_COMPLETE) begin
            pending_d[grant_q] = 1'b0;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_write_req[i] && !req_busy[i]) begin
                pending_d[i]    = 1'b1;
                lat_slave_d[i]  = req_slave_addr[7*i +: 7];
                lat_reg_d[i]    = req_reg_addr[8*i +: 8];
                lat_data_d[i]   = req_write_data[8*i +: 8];
                lat_chan_d[i]   = req_channel[8*i +: 8];
                lat_single_d[i] = req_single_byte[i];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rr_ptr_d     = rr_ptr_q;
        cur_chan_d   = cur_chan_q;
        chan_valid_d = chan_valid_q;
        watchdog_d   = watchdog_q;
        error_d      = error_q;
        out_slave_d  = out_slave_q;
        out_reg_d    = out_reg_q;
        out_data_d   = out_data_q;
        out_single_d = out_single_q;
        out_wreq_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rr_found) begin
                    grant_d  = rr_pick;
                    rr_ptr_d = (rr_pick == GW'(NUM_REQ - 1)) ? '0 : rr_pick + 1'b1;
                    state_d  = ST_ARB;
                end
            end
            ST_ARB: begin
                error_d = 1'b0;
                state_d = mux_needed ? ST_MUX_SEND : ST_XFER_SEND;
            end
            ST_MUX_SEND: begin
                watchdog_d = '0;
                if (!i2c_busy) begin
                    out_slave_d  = MUX_ADDR;
                    out_reg_d    = 8'h00;
                    out_data_d   = sel_chan;
                    out_single_d = 1'b1;
                    out_wreq_d   = 1'b1;
                    state_d      = ST_MUX_WAIT_BUSY;
                end
            end
            ST_MUX_WAIT_BUSY: begin
                if (wd_expired) begin
                    error_d      = 1'b1;
                    chan_valid_d = 1'b0;
                    state_d      = ST_COMPLETE;
                end else begin
                    watchdog_d = watchdog_q + 1'b1;
                    if (i2c_busy) begin
                        state_d = ST_MUX_WAIT_DONE;
                    end
                end
            end
            ST_MUX_WAIT_DONE: begin
                watchdog_d = watchdog_q + 1'b1;
                if (i2c_done) begin
                    if (i2c_ack_error) begin
                        error_d      = 1'b1;
                        chan_valid_d = 1'b0;
                        state_d      = ST_COMPLETE;
                    end else begin
                        cur_chan_d   = sel_chan;
                        chan_valid_d = 1'b1;
                        state_d      = ST_XFER_SEND;
                    end
                end else if (wd_expired) begin
                    error_d      = 1'b1;
                    chan_valid_d = 1'b0;
                    state_d      = ST_COMPLETE;
                end
            end
            ST_XFER_SEND: begin
                watchdog_d = '0;
                if (!i2c_busy) begin
                    out_slave_d  = sel_slave;
                    out_reg_d    = sel_reg;
                    out_data_d   = sel_data;
                    out_single_d = sel_single;
                    out_wreq_d   = 1'b1;
                    state_d      = ST_XFER_WAIT_BUSY;
                end
            end
            ST_XFER_WAIT_BUSY: begin
                if (wd_expired) begin
                    error_d      = 1'b1;
                    chan_valid_d = 1'b0;
                    state_d      = ST_COMPLETE;
                end else begin
                    watchdog_d = watchdog_q + 1'b1;
                    if (i2c_busy) begin
                        state_d = ST_XFER_WAIT_DONE;
                    end
                end
            end
            ST_XFER_WAIT_DONE: begin
                watchdog_d = watchdog_q + 1'b1;
                if (i2c_done) begin
                    error_d = i2c_ack_error;
                    // A requester writing the mux directly also moves the tracked channel.
                    if (sel_slave == MUX_ADDR) begin
                        if (i2c_ack_error) begin
                            chan_valid_d = 1'b0;
                        end else begin
                            cur_chan_d   = sel_data;
                            chan_valid_d = 1'b1;
                        end
                    end
                    state_d = ST_COMPLETE;
                end else if (wd_expired) begin
                    error_d      = 1'b1;
                    chan_valid_d = 1'b0;
                    state_d      = ST_COMPLETE;
                end
            end
            ST_COMPLETE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            pending_q    <= '0;
            grant_q      <= '0;
            rr_ptr_q     <= '0;
            cur_chan_q   <= 8'h00;
            chan_valid_q <= 1'b0;
            watchdog_q   <= '0;
            error_q      <= 1'b0;
            out_slave_q  <= '0;
            out_reg_q    <= '0;
            out_data_q   <= '0;
            out_single_q <= 1'b0;
            out_wreq_q   <= 1'b0;
            lat_single_q <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                lat_slave_q[i] <= '0;
                lat_reg_q[i]   <= '0;
                lat_data_q[i]  <= '0;
                lat_chan_q[i]  <= '0;
            end
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            grant_q      <= grant_d;
            rr_ptr_q     <= rr_ptr_d;
            cur_chan_q   <= cur_chan_d;
            chan_valid_q <= chan_valid_d;
            watchdog_q   <= watchdog_d;
            error_q      <= error_d;
            out_slave_q  <= out_slave_d;
            out_reg_q    <= out_reg_d;
            out_data_q   <= out_data_d;
            out_single_q <= out_single_d;
            out_wreq_q   <= out_wreq_d;
            lat_single_q <= lat_single_d;
            lat_slave_q  <= lat_slave_d;
            lat_reg_q    <= lat_reg_d;
            lat_data_q   <= lat_data_d;
            lat_chan_q   <= lat_chan_d;
        end
    end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed bench for i2c_bus_arbiter: a behavioural I2C master logs every write it is handed,
// and each scenario task compares logged transactions and completions against hand-computed values.
module tb_i2c_bus_arbiter;

    localparam int NUM_REQ = 3;
    localparam int TO      = 64;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic [NUM_REQ*7-1:0] req_slave_addr;
    logic [NUM_REQ*8-1:0] req_reg_addr;
    logic [NUM_REQ*8-1:0] req_write_data;
    logic [NUM_REQ-1:0]   req_single_byte;
    logic [NUM_REQ*8-1:0] req_channel;
    logic [NUM_REQ-1:0]   req_write_req;
    logic [NUM_REQ-1:0]   req_busy;
    logic [NUM_REQ-1:0]   req_done;
    logic [NUM_REQ-1:0]   req_ack_error;
    logic [6:0]           i2c_slave_addr;
    logic [7:0]           i2c_reg_addr;
    logic [7:0]           i2c_write_data;
    logic                 i2c_single_byte;
    logic                 i2c_write_req;
    logic                 i2c_busy;
    logic                 i2c_done;
    logic                 i2c_ack_error;

    i2c_bus_arbiter #(
        .NUM_REQ(NUM_REQ),
        .MUX_ADDR(7'h74),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_slave_addr(req_slave_addr),
        .req_reg_addr(req_reg_addr),
        .req_write_data(req_write_data),
        .req_single_byte(req_single_byte),
        .req_channel(req_channel),
        .req_write_req(req_write_req),
        .req_busy(req_busy),
        .req_done(req_done),
        .req_ack_error(req_ack_error),
        .i2c_slave_addr(i2c_slave_addr),
        .i2c_reg_addr(i2c_reg_addr),
        .i2c_write_data(i2c_write_data),
        .i2c_single_byte(i2c_single_byte),
        .i2c_write_req(i2c_write_req),
        .i2c_busy(i2c_busy),
        .i2c_done(i2c_done),
        .i2c_ack_error(i2c_ack_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] addr;
        logic [7:0] rega;
        logic [7:0] data;
        logic       single;
        int         cyc;
    } txn_t;

    typedef struct {
        int   idx;
        logic err;
        int   cyc;
    } done_t;

    txn_t  txn_q[$];
    done_t done_q[$];
    int    cyc = 0;
    int    checks = 0;
    int    failures = 0;
    int    multi_done = 0;
    int    req_cyc = 0;
    int    mst_cnt = 0;
    int    mst_len = 3;
    bit    mst_hang = 0;
    bit    mst_nak_mux = 0;
    bit    mst_nak_now = 0;
    bit    mst_spurious = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Completion monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if ($countones(req_done) > 1) multi_done++;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_done[i]) begin
                    done_t d;
                    d.idx = i;
                    d.err = req_ack_error[i];
                    d.cyc = cyc;
                    done_q.push_back(d);
                end
            end
        end
    end

    // Behavioural master: busy for mst_len cycles after a request, then a done pulse.
    initial begin
        i2c_busy = 1'b0;
        i2c_done = 1'b0;
        i2c_ack_error = 1'b0;
        forever begin
            @(negedge clk);
            i2c_done = 1'b0;
            i2c_ack_error = 1'b0;
            if (!rst_n) begin
                i2c_busy = 1'b0;
                mst_cnt = 0;
            end else if (mst_spurious) begin
                mst_spurious = 0;
                i2c_busy = 1'b0;
                i2c_done = 1'b1;
            end else if (mst_cnt != 0) begin
                mst_cnt--;
                if (mst_cnt == 0) begin
                    i2c_busy = 1'b0;
                    i2c_done = 1'b1;
                    i2c_ack_error = mst_nak_now;
                end
            end else if (i2c_write_req === 1'b1) begin
                txn_t t;
                t.addr = i2c_slave_addr;
                t.rega = i2c_reg_addr;
                t.data = i2c_write_data;
                t.single = i2c_single_byte;
                t.cyc = cyc;
                txn_q.push_back(t);
                i2c_busy = 1'b1;
                if (!mst_hang) begin
                    mst_cnt = mst_len;
                    mst_nak_now = mst_nak_mux && (i2c_slave_addr == 7'h74);
                end
            end
        end
    end

    function automatic logic [23:0] pk(input txn_t t);
        return {t.addr, t.rega, t.data, t.single};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_logs();
        txn_q.delete();
        done_q.delete();
    endtask

    task automatic pulse_req(input logic [NUM_REQ-1:0] mask, input logic [6:0] sa,
                             input logic [7:0] ra, input logic [7:0] wd,
                             input logic sb, input logic [7:0] ch);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (mask[i]) begin
                req_slave_addr[7*i +: 7] = sa + 7'(i);
                req_reg_addr[8*i +: 8]   = ra;
                req_write_data[8*i +: 8] = wd;
                req_single_byte[i]       = sb;
                req_channel[8*i +: 8]    = ch;
            end
        end
        req_write_req = mask;
        req_cyc = cyc;
        @(negedge clk);
        req_write_req = '0;
    endtask

    task automatic wait_dones(input int n, input int budget, output bit ok);
        int k = 0;
        while (done_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        ok = (done_q.size() >= n);
    endtask

    task automatic test_reset();
        req_slave_addr = '0;
        req_reg_addr = '0;
        req_write_data = '0;
        req_single_byte = '0;
        req_channel = '0;
        req_write_req = '0;
        rst_n = 1'b0;
        tick(3);
        checks++;
        if ({req_busy, req_done, req_ack_error} !== 9'b0) begin
            failures++;
            $display("[TB] FAIL reset_req_outputs: got %b expected 0", {req_busy, req_done, req_ack_error});
        end
        checks++;
        if (i2c_write_req !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_write_req: got %b expected 0", i2c_write_req);
        end
        checks++;
        if ({i2c_slave_addr, i2c_reg_addr, i2c_write_data, i2c_single_byte} !== 24'h0) begin
            failures++;
            $display("[TB] FAIL reset_i2c_fields: got %h expected 0",
                     {i2c_slave_addr, i2c_reg_addr, i2c_write_data, i2c_single_byte});
        end
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_first_access();
        bit ok;
        int lat;
        clear_logs();
        pulse_req(3'b001, 7'h39, 8'h41, 8'h10, 1'b0, 8'h20);
        checks++;
        if (req_busy !== 3'b001) begin
            failures++;
            $display("[TB] FAIL first_busy: got %b expected 001", req_busy);
        end
        wait_dones(1, 200, ok);
        tick(2);
        checks++;
        if (ok !== 1'b1 || txn_q.size() != 2) begin
            failures++;
            $display("[TB] FAIL first_txn_count: got done=%0d txns=%0d expected 1/2", done_q.size(), txn_q.size());
        end else begin
            checks++;
            if (pk(txn_q[0]) !== {7'h74, 8'h00, 8'h20, 1'b1}) begin
                failures++;
                $display("[TB] FAIL first_mux_write: got %h expected %h", pk(txn_q[0]), {7'h74, 8'h00, 8'h20, 1'b1});
            end
            checks++;
            if (pk(txn_q[1]) !== {7'h39, 8'h41, 8'h10, 1'b0}) begin
                failures++;
                $display("[TB] FAIL first_data_write: got %h expected %h", pk(txn_q[1]), {7'h39, 8'h41, 8'h10, 1'b0});
            end
            lat = txn_q[0].cyc - req_cyc;
            checks++;
            if (lat !== 4) begin
                failures++;
                $display("[TB] FAIL first_latency: got %0d expected 4", lat);
            end
            checks++;
            if (done_q[0].idx !== 0 || done_q[0].err !== 1'b0) begin
                failures++;
                $display("[TB] FAIL first_done: got idx=%0d err=%b expected idx=0 err=0", done_q[0].idx, done_q[0].err);
            end
        end
        clear_logs();
        pulse_req(3'b001, 7'h39, 8'h42, 8'h11, 1'b0, 8'h20);
        wait_dones(1, 200, ok);
        tick(2);
        checks++;
        if (ok !== 1'b1 || txn_q.size() != 1) begin
            failures++;
            $display("[TB] FAIL same_chan_no_mux: got txns=%0d expected 1", txn_q.size());
        end else begin
            checks++;
            if (pk(txn_q[0]) !== {7'h39, 8'h42, 8'h11, 1'b0}) begin
                failures++;
                $display("[TB] FAIL same_chan_data: got %h expected %h", pk(txn_q[0]), {7'h39, 8'h42, 8'h11, 1'b0});
            end
        end
    endtask

    task automatic test_channel_switch();
        bit ok;
        clear_logs();
        pulse_req(3'b010, 7'h4F, 8'h00, 8'h99, 1'b0, 8'h01);
        wait_dones(1, 200, ok);
        tick(2);
        checks++;
        if (ok !== 1'b1 || txn_q.size() != 2) begin
            failures++;
            $display("[TB] FAIL switch_txn_count: got txns=%0d expected 2", txn_q.size());
        end else begin
            checks++;
            if (pk(txn_q[0]) !== {7'h74, 8'h00, 8'h01, 1'b1} || pk(txn_q[1]) !== {7'h50, 8'h00, 8'h99, 1'b0}) begin
                failures++;
                $display("[TB] FAIL switch_writes: got %h,%h expected %h,%h", pk(txn_q[0]), pk(txn_q[1]),
                         {7'h74, 8'h00, 8'h01, 1'b1}, {7'h50, 8'h00, 8'h99, 1'b0});
            end
            checks++;
            if (done_q[0].idx !== 1 || done_q[0].err !== 1'b0) begin
                failures++;
                $display("[TB] FAIL switch_done: got idx=%0d err=%b expected idx=1 err=0", done_q[0].idx, done_q[0].err);
            end
        end
        clear_logs();
        pulse_req(3'b100, 7'h4F, 8'h02, 8'h03, 1'b0, 8'h01);
        wait_dones(1, 200, ok);
        tick(2);
        checks++;
        if (ok !== 1'b1 || txn_q.size() != 1 || done_q[0].idx !== 2) begin
            failures++;
            $display("[TB] FAIL switch_channel_kept: got txns=%0d done=%0d expected 1 txn from req2", txn_q.size(), done_q.size());
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        logic [5:0] order;
        logic [20:0] addrs;
        clear_logs();
        pulse_req(3'b001, 7'h20, 8'h00, 8'h00, 1'b0, 8'h01);
        wait_dones(1, 200, ok);
        tick(2);
        for (int r = 0; r < 3; r++) begin
            clear_logs();
            pulse_req(3'b111, 7'h10, 8'h05, 8'hA0, 1'b0, 8'h01);
            wait_dones(3, 400, ok);
            tick(2);
            checks++;
            if (ok !== 1'b1 || txn_q.size() != 3) begin
                failures++;
                $display("[TB] FAIL rr_round%0d_count: got done=%0d txns=%0d expected 3/3", r, done_q.size(), txn_q.size());
            end else begin
                order = {2'(done_q[0].idx), 2'(done_q[1].idx), 2'(done_q[2].idx)};
                addrs = {txn_q[0].addr, txn_q[1].addr, txn_q[2].addr};
                checks++;
                if (order !== {2'd1, 2'd2, 2'd0}) begin
                    failures++;
                    $display("[TB] FAIL rr_round%0d_order: got %b expected 011000", r, order);
                end
                checks++;
                if (addrs !== {7'h11, 7'h12, 7'h10}) begin
                    failures++;
                    $display("[TB] FAIL rr_round%0d_addrs: got %h expected %h", r, addrs, {7'h11, 7'h12, 7'h10});
                end
            end
        end
        checks++;
        if (multi_done !== 0) begin
            failures++;
            $display("[TB] FAIL rr_single_grant: got %0d multi-done cycles expected 0", multi_done);
        end
    endtask

    task automatic test_busy_ignore();
        bit ok;
        clear_logs();
        pulse_req(3'b001, 7'h22, 8'h01, 8'h55, 1'b0, 8'h01);
        tick(1);
        pulse_req(3'b001, 7'h23, 8'h01, 8'h66, 1'b0, 8'h01);
        wait_dones(1, 200, ok);
        tick(20);
        checks++;
        if (ok !== 1'b1 || txn_q.size() != 1 || done_q.size() != 1) begin
            failures++;
            $display("[TB] FAIL busy_ignore_count: got txns=%0d done=%0d expected 1/1", txn_q.size(), done_q.size());
        end else begin
            checks++;
            if (pk(txn_q[0]) !== {7'h22, 8'h01, 8'h55, 1'b0}) begin
                failures++;
                $display("[TB] FAIL busy_ignore_data: got %h expected %h", pk(txn_q[0]), {7'h22, 8'h01, 8'h55, 1'b0});
            end
        end
    endtask

    task automatic test_mux_nak();
        bit ok;
        clear_logs();
        mst_nak_mux = 1;
        pulse_req(3'b001, 7'h39, 8'h41, 8'h10, 1'b0, 8'h08);
        wait_dones(1, 200, ok);
        tick(10);
        mst_nak_mux = 0;
        checks++;
        if (ok !== 1'b1 || txn_q.size() != 1) begin
            failures++;
            $display("[TB] FAIL nak_txn_count: got txns=%0d expected 1", txn_q.size());
        end else begin
            checks++;
            if (pk(txn_q[0]) !== {7'h74, 8'h00, 8'h08, 1'b1}) begin
                failures++;
                $display("[TB] FAIL nak_mux_write: got %h expected %h", pk(txn_q[0]), {7'h74, 8'h00, 8'h08, 1'b1});
            end
            checks++;
            if (done_q[0].idx !== 0 || done_q[0].err !== 1'b1) begin
                failures++;
                $display("[TB] FAIL nak_done: got idx=%0d err=%b expected idx=0 err=1", done_q[0].idx, done_q[0].err);
            end
        end
        clear_logs();
        pulse_req(3'b001, 7'h39, 8'h41, 8'h10, 1'b0, 8'h08);
        wait_dones(1, 200, ok);
        tick(2);
        checks++;
        if (ok !== 1'b1 || txn_q.size() != 2 || done_q[0].err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL nak_retry: got txns=%0d expected 2 with ack", txn_q.size());
        end else begin
            checks++;
            if (pk(txn_q[0]) !== {7'h74, 8'h00, 8'h08, 1'b1}) begin
                failures++;
                $display("[TB] FAIL nak_retry_mux: got %h expected %h", pk(txn_q[0]), {7'h74, 8'h00, 8'h08, 1'b1});
            end
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int wait_len;
        clear_logs();
        mst_hang = 1;
        pulse_req(3'b010, 7'h29, 8'h05, 8'h06, 1'b0, 8'h08);
        wait_dones(1, 300, ok);
        checks++;
        if (ok !== 1'b1 || txn_q.size() != 1) begin
            failures++;
            $display("[TB] FAIL timeout_done: got done=%0d txns=%0d expected 1/1", done_q.size(), txn_q.size());
        end else begin
            checks++;
            if (done_q[0].idx !== 1 || done_q[0].err !== 1'b1) begin
                failures++;
                $display("[TB] FAIL timeout_status: got idx=%0d err=%b expected idx=1 err=1", done_q[0].idx, done_q[0].err);
            end
            wait_len = done_q[0].cyc - txn_q[0].cyc;
            checks++;
            if (wait_len !== TO) begin
                failures++;
                $display("[TB] FAIL timeout_cycles: got %0d expected %0d", wait_len, TO);
            end
        end
        mst_hang = 0;
        mst_spurious = 1;
        tick(10);
        checks++;
        if (done_q.size() != 1 || txn_q.size() != 1) begin
            failures++;
            $display("[TB] FAIL timeout_late_done: got done=%0d txns=%0d expected 1/1", done_q.size(), txn_q.size());
        end
        clear_logs();
        pulse_req(3'b010, 7'h29, 8'h05, 8'h07, 1'b0, 8'h08);
        wait_dones(1, 200, ok);
        tick(2);
        checks++;
        if (ok !== 1'b1 || txn_q.size() != 2) begin
            failures++;
            $display("[TB] FAIL timeout_remux: got txns=%0d expected 2", txn_q.size());
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int k;
        clear_logs();
        mst_len = 20;
        pulse_req(3'b100, 7'h31, 8'h01, 8'h02, 1'b0, 8'h08);
        k = 0;
        while (txn_q.size() < 1 && k < 50) begin
            tick(1);
            k++;
        end
        tick(3);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({req_busy, req_done, req_ack_error, i2c_write_req} !== 10'b0) begin
            failures++;
            $display("[TB] FAIL midreset_ctrl: got %b expected 0", {req_busy, req_done, req_ack_error, i2c_write_req});
        end
        checks++;
        if ({i2c_slave_addr, i2c_reg_addr, i2c_write_data, i2c_single_byte} !== 24'h0) begin
            failures++;
            $display("[TB] FAIL midreset_fields: got %h expected 0",
                     {i2c_slave_addr, i2c_reg_addr, i2c_write_data, i2c_single_byte});
        end
        tick(2);
        rst_n = 1'b1;
        mst_len = 3;
        tick(2);
        checks++;
        if (txn_q.size() != 1 || done_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL midreset_abort: got txns=%0d done=%0d expected 1/0", txn_q.size(), done_q.size());
        end
        clear_logs();
        pulse_req(3'b100, 7'h31, 8'h01, 8'h02, 1'b0, 8'h08);
        wait_dones(1, 200, ok);
        tick(2);
        checks++;
        if (ok !== 1'b1 || txn_q.size() != 2) begin
            failures++;
            $display("[TB] FAIL midreset_remux: got txns=%0d expected 2", txn_q.size());
        end else begin
            checks++;
            if (pk(txn_q[0]) !== {7'h74, 8'h00, 8'h08, 1'b1} || pk(txn_q[1]) !== {7'h33, 8'h01, 8'h02, 1'b0}) begin
                failures++;
                $display("[TB] FAIL midreset_writes: got %h,%h expected %h,%h", pk(txn_q[0]), pk(txn_q[1]),
                         {7'h74, 8'h00, 8'h08, 1'b1}, {7'h33, 8'h01, 8'h02, 1'b0});
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_access();
        test_channel_switch();
        test_round_robin();
        test_busy_ignore();
        test_mux_nak();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule

// File: doc/i2c_bus_arbiter.md
Name: i2c_bus_arbiter

Overview:
- Shares the single I2C master between NUM_REQ requesters: the ADV7511 init sequencer, an EDID reader and an HPD poller.
- Requesters use the same request/busy/done/ack_error handshake they would use with the master directly.
- Arbitration is round-robin.
- Tracks the PCA9548 mux channel and inserts a channel-select write automatically when the granted requester needs a different channel.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
MUX_ADDR, 7'h74, PCA9548 7-bit address
TIMEOUT_CYCLES, 1048576, watchdog limit per master transaction (cycles)

Ports:
clk  in  1  system clock
rst_n  in  1  async active-low reset
req_slave_addr  in  NUM_REQ*7  per-requester slave address, requester i at [7i+:7]
req_reg_addr  in  NUM_REQ*8  per-requester register address
req_write_data  in  NUM_REQ*8  per-requester data byte
req_single_byte  in  NUM_REQ  per-requester no-register-address write
req_channel  in  NUM_REQ*8  per-requester required mux channel mask
req_write_req  in  NUM_REQ  one-cycle request pulse per requester
req_busy  out  NUM_REQ  request pending or in service
req_done  out  NUM_REQ  one-cycle completion pulse
req_ack_error  out  NUM_REQ  NAK/timeout status, valid with req_done
i2c_slave_addr  out  7  to master
i2c_reg_addr  out  8  to master
i2c_write_data  out  8  to master
i2c_single_byte  out  1  to master
i2c_write_req  out  1  one-cycle pulse to master
i2c_busy  in  1  master busy
i2c_done  in  1  master completion pulse
i2c_ack_error  in  1  master NAK flag, valid with i2c_done

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - All outputs 0.
  - pending=0, rr_ptr=0.
  - cur_chan=8'h00, chan_valid=0, watchdog=0.
  - State IDLE.
- Request capture:
  - A req_write_req[i] pulse while req_busy[i]=0 sets pending[i] and latches that requester's fields the same edge.
  - req_busy[i] is high from the next cycle until the req_done[i] cycle; it is low in the req_done cycle.
  - Pulses while req_busy[i]=1 are ignored.
  - If capture and clear of pending[i] coincide, capture wins.
- Arbitration:
  - In IDLE with pending!=0, grant the first pending index at or after rr_ptr, wrapping modulo NUM_REQ.
  - Then rr_ptr <= grant+1, wrapping.
  - Exactly one grant at a time.
- Mux decision:
  - A mux write is needed if chan_valid=0 or cur_chan!=latched channel.
  - Skip it when the granted request itself targets MUX_ADDR.
- State machine:
  - IDLE -> ARB: pending!=0.
  - ARB -> MUX_SEND if a mux write is needed, else XFER_SEND.
  - MUX_SEND: when i2c_busy=0, drive {MUX_ADDR, reg 8'h00, data=channel, single_byte=1}, pulse i2c_write_req -> MUX_WAIT_BUSY.
  - MUX_WAIT_BUSY: i2c_busy=1 -> MUX_WAIT_DONE.
  - MUX_WAIT_DONE on i2c_done:
    - NAK -> chan_valid<=0, COMPLETE with error=1.
    - ACK -> cur_chan<=channel, chan_valid<=1, XFER_SEND.
  - XFER_SEND / XFER_WAIT_BUSY / XFER_WAIT_DONE: same handshake with the latched fields.
    - On i2c_done, error<=i2c_ack_error.
    - If the target is MUX_ADDR with ACK, cur_chan<=data and chan_valid<=1.
    - If the target is MUX_ADDR with NAK, chan_valid<=0.
  - COMPLETE: pulse req_done[grant], drive req_ack_error[grant]=error for that cycle, clear pending[grant] -> IDLE.
- Output timing:
  - i2c_* address/data outputs are registered and stable from the i2c_write_req cycle through i2c_done.
  - i2c_write_req is high exactly one cycle per transaction.
- Watchdog:
  - Counts every cycle in *_WAIT_BUSY/*_WAIT_DONE and resets on entering *_SEND.
  - Reaching TIMEOUT_CYCLES-1 -> error=1, chan_valid=0, COMPLETE.
  - A late i2c_done after a timeout is ignored.
- Latency: minimum of 4 cycles from req_write_req to i2c_write_req (capture, IDLE, ARB, SEND). A mux insert adds one full master transaction.
- Reset mid-operation: everything returns to reset values immediately. The master is not notified and must be reset from the same rst_n.

Test Plan:
- Single requester, channel 8'h20, first access: req0 pulse -> master sees mux write {74,single,20} then {39,41,10}; req_done[0] with ack_error=0; no second mux write on a following same-channel request.
- Channel switch: req1 on channel 8'h01 after req0 on 8'h20 -> mux write data 8'h01 inserted; cur_chan=8'h01.
- Round-robin: req0, req1 and req2 pulsed in the same cycle, repeated 3 rounds -> grant order 0,1,2,0,1,2..., never 2 grants outstanding.
- Mux NAK: i2c_ack_error=1 on mux write -> no data transaction issued, req_done+ack_error=1, next request re-issues mux write.
- Timeout: TIMEOUT_CYCLES=64, master never asserts i2c_done -> req_done with ack_error=1 at cycle 64 of waiting; a later spurious i2c_done causes no output.
- Reset during XFER_WAIT_DONE -> all outputs 0 next sample, pending cleared, next request performs a mux write (chan_valid=0).
